// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bar-graph datapath: controller state
// encoding, bar geometry and the thermometer decode used by the display logic.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_LEVEL = 16;
  localparam int LED_W     = MAX_LEVEL;

  // Level n lights the low n LEDs; level 0 is dark, level LED_W is full bar.
  function automatic logic [LED_W-1:0] therm_decode(input int unsigned lvl);
    logic [LED_W-1:0] bar;
    bar = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      bar[i] = (lvl > i);
    end
    return bar;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: pulses tick once every TICK_DIV enabled cycles.
// The count holds while en is low and returns to zero on clr.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_sweep_controller.sv
// Sweep sequencer for the LED bar: steps a level register between two
// programmed endpoints with bounce, pass counting and pause/resume/abort.
module led_sweep_controller #(
  parameter int TICK_DIV = 25_000_000,
  parameter int LVL_W    = 5,
  parameter int LED_W    = 16,
  parameter int REP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LVL_W-1:0] start_num,
  input  logic [LVL_W-1:0] end_num,
  input  logic             up_down,
  input  logic             bounce,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic [LVL_W-1:0] level,
  output logic [LED_W-1:0] led_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] pass_cnt
);

  import led_pkg::*;

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(LED_W);

  state_t           state, state_next;
  logic [LVL_W-1:0] origin, target;
  logic             bounce_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] pass_inc;
  logic             cfg_ok;
  logic             tick, run_en;
  logic             accept, reject, abort, step, pass_end;

  assign cfg_ok = (start_num <= MAX_LVL) && (end_num <= MAX_LVL) &&
                  (up_down ? (start_num <= end_num) : (start_num >= end_num));

  assign pass_inc = pass_cnt + REP_W'(1);

  // A stop in RUN freezes the prescaler in the same cycle it takes effect.
  assign run_en = (state == RUN) && !stop;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .clr  (accept || abort),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    abort      = 1'b0;
    step       = 1'b0;
    pass_end   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_next = PAUSE;
        end else if (tick) begin
          if (level != target) begin
            step = 1'b1;
          end else begin
            pass_end = 1'b1;
            if (rep_q != '0 && pass_inc == rep_q) state_next = DONE;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the latched sweep configuration is reset along with the datapath so
  // nothing downstream ever observes X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin   <= '0;
      target   <= '0;
      bounce_q <= 1'b0;
      rep_q    <= '0;
      level    <= '0;
      pass_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      busy <= (state_next == RUN) || (state_next == PAUSE);
      done <= (state_next == DONE);
      err  <= reject;
      if (accept) begin
        origin   <= start_num;
        target   <= end_num;
        bounce_q <= bounce;
        rep_q    <= repeat_cnt;
        level    <= start_num;
        pass_cnt <= '0;
      end else if (abort) begin
        level    <= '0;
        pass_cnt <= '0;
      end else if (step) begin
        level <= (level < target) ? level + LVL_W'(1) : level - LVL_W'(1);
      end else if (pass_end) begin
        pass_cnt <= pass_inc;
        // On the final pass the level stays on the endpoint it just showed.
        if (state_next != DONE) begin
          if (bounce_q) begin
            origin <= target;
            target <= origin;
          end else begin
            level <= origin;
          end
        end
      end
    end
  end

  assign led_out = LED_W'(therm_decode(32'(level)));

endmodule

// File: tb/tb_led_sweep_controller.sv
// Directed bench for led_sweep_controller with TICK_DIV=4: config accept/reject
// table plus hand-sequenced sweep, bounce, pause, reset and wrap scenarios.
module tb_led_sweep_controller;

  localparam int TICK_DIV = 4;
  localparam int LVL_W    = 5;
  localparam int LED_W    = 16;
  localparam int REP_W    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, up_down, bounce;
  logic [LVL_W-1:0] start_num, end_num, level;
  logic [REP_W-1:0] repeat_cnt, pass_cnt;
  logic [LED_W-1:0] led_out;
  logic             busy, done, err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [LVL_W-1:0] s;
    logic [LVL_W-1:0] e;
    logic             ud;
    logic             b;
    logic [REP_W-1:0] rep;
    logic             exp_err;
    logic [LVL_W-1:0] exp_lvl;
  } vec_t;

  vec_t vecs[7];
  int   bounce_lvl[26];

  always #5 clk = ~clk;

  led_sweep_controller #(
    .TICK_DIV (TICK_DIV),
    .LVL_W    (LVL_W),
    .LED_W    (LED_W),
    .REP_W    (REP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .start_num  (start_num),
    .end_num    (end_num),
    .up_down    (up_down),
    .bounce     (bounce),
    .repeat_cnt (repeat_cnt),
    .level      (level),
    .led_out    (led_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pass_cnt   (pass_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bar(input int l);
    return (32'd1 << l) - 32'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int s, input int e, input logic ud, input logic b, input int rep);
    start_num  = LVL_W'(s);
    end_num    = LVL_W'(e);
    up_down    = ud;
    bounce     = b;
    repeat_cnt = REP_W'(rep);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic abort_run(input string tag);
    pulse_stop();
    check({tag, " paused busy"}, busy, 1);
    pulse_stop();
    check({tag, " abort level"}, level, 0);
    check({tag, " abort led"}, led_out, 0);
    check({tag, " abort busy"}, busy, 0);
    check({tag, " abort done"}, done, 0);
    check({tag, " abort pass_cnt"}, pass_cnt, 0);
  endtask

  initial begin
    vecs[0] = '{5'd17, 5'd3,  1'b0, 1'b0, 4'd1, 1'b1, 5'd0};
    vecs[1] = '{5'd9,  5'd4,  1'b1, 1'b0, 4'd1, 1'b1, 5'd0};
    vecs[2] = '{5'd4,  5'd9,  1'b0, 1'b0, 4'd1, 1'b1, 5'd0};
    vecs[3] = '{5'd3,  5'd20, 1'b1, 1'b0, 4'd1, 1'b1, 5'd0};
    vecs[4] = '{5'd16, 5'd16, 1'b0, 1'b0, 4'd1, 1'b0, 5'd16};
    vecs[5] = '{5'd0,  5'd16, 1'b1, 1'b1, 4'd0, 1'b0, 5'd0};
    vecs[6] = '{5'd7,  5'd2,  1'b0, 1'b0, 4'd3, 1'b0, 5'd7};
    bounce_lvl = '{0,0,0,0, 1,1,1,1, 2,2,2,2,2,2,2,2, 1,1,1,1, 0,0,0,0,0,0};

    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    set_cfg(0, 0, 1'b1, 1'b0, 0);
    #12;
    check("reset level", level, 0);
    check("reset led", led_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset pass_cnt", pass_cnt, 0);
    rst = 1'b0;
    step();

    // Accept/reject table, each applied from IDLE with level 0.
    for (int i = 0; i < 7; i++) begin
      set_cfg(int'(vecs[i].s), int'(vecs[i].e), vecs[i].ud, vecs[i].b, int'(vecs[i].rep));
      pulse_start();
      check($sformatf("vec%0d err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d busy", i), busy, !vecs[i].exp_err);
      check($sformatf("vec%0d level", i), level, vecs[i].exp_lvl);
      check($sformatf("vec%0d led", i), led_out, bar(int'(vecs[i].exp_lvl)));
      step();
      check($sformatf("vec%0d err one cycle", i), err, 0);
      if (!vecs[i].exp_err) abort_run($sformatf("vec%0d", i));
    end

    // Up sweep 3 -> 6, single pass.
    set_cfg(3, 6, 1'b1, 1'b0, 1);
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      int exp_l;
      exp_l = (c <= 4) ? 3 : (c <= 8) ? 4 : (c <= 12) ? 5 : 6;
      check($sformatf("up c%0d level", c), level, exp_l);
      check($sformatf("up c%0d done", c), done, c == 17);
      check($sformatf("up c%0d busy", c), busy, c <= 16);
      if (c == 17) begin
        check("up led at done", led_out, 32'h003F);
        check("up pass_cnt at done", pass_cnt, 1);
      end
      if (c < 18) step();
    end
    check("up led held", led_out, 32'h003F);

    // Bounce 0 -> 2 -> 0, two passes.
    set_cfg(0, 2, 1'b1, 1'b1, 2);
    pulse_start();
    for (int c = 1; c <= 26; c++) begin
      check($sformatf("bounce c%0d level", c), level, bounce_lvl[c-1]);
      check($sformatf("bounce c%0d done", c), done, c == 25);
      check($sformatf("bounce c%0d pass_cnt", c), pass_cnt, (c >= 25) ? 2 : (c >= 13) ? 1 : 0);
      if (c < 26) step();
    end
    check("bounce busy after", busy, 0);

    // Pause at level 5 with prescaler count 1, then resume and abort.
    set_cfg(3, 6, 1'b1, 1'b0, 1);
    pulse_start();
    for (int c = 2; c <= 10; c++) step();
    check("pause pre level", level, 5);
    pulse_stop();
    for (int k = 0; k < 20; k++) begin
      check($sformatf("pause hold %0d level", k), level, 5);
      check($sformatf("pause hold %0d busy", k), busy, 1);
      step();
    end
    pulse_start();
    check("resume r1 level", level, 5);
    step();
    check("resume r2 level", level, 5);
    step();
    check("resume r3 level", level, 5);
    step();
    check("resume r4 level", level, 6);
    check("resume r4 done", done, 0);
    abort_run("pause");

    // Async reset between edges mid-run.
    set_cfg(3, 6, 1'b1, 1'b0, 1);
    pulse_start();
    for (int c = 2; c <= 6; c++) step();
    check("pre-reset level", level, 4);
    #2;
    rst = 1'b1;
    #1;
    check("async rst level", level, 0);
    check("async rst led", led_out, 0);
    check("async rst busy", busy, 0);
    #1;
    rst = 1'b0;
    step();
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("start+stop busy", busy, 0);
    check("start+stop err", err, 0);
    check("start+stop level", level, 0);
    step();
    check("start+stop busy later", busy, 0);

    // Infinite run 15 <-> 16 reload, pass_cnt wraps after 16 passes.
    set_cfg(15, 16, 1'b1, 1'b0, 0);
    pulse_start();
    for (int c = 1; c <= 140; c++) begin
      int exp_l;
      exp_l = (((c - 1) / 4) % 2 == 1) ? 16 : 15;
      check($sformatf("inf c%0d level", c), level, exp_l);
      check($sformatf("inf c%0d led", c), led_out, (exp_l == 16) ? 32'hFFFF : 32'h7FFF);
      check($sformatf("inf c%0d pass_cnt", c), pass_cnt, ((c - 1) / 8) % 16);
      check($sformatf("inf c%0d done", c), done, 0);
      step();
    end
    abort_run("inf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_sweep_controller.md
Name: led_sweep_controller

Overview:
- Sequencer for the LED bar-graph datapath. Owns the step timing and the level register that drives the thermometer LED output.
- Runs programmed sweeps between two levels (0..16). Supports up or down direction, optional bounce, a pass count, and pause/resume/abort from push-button pulses.
- Sits between the board buttons/switches and the 16-LED bar. Replaces free-running counter-plus-divider operation with a controlled run.

Parameters:
- TICK_DIV, 25_000_000, clock cycles per level step (minimum 1; 1 means step every cycle).
- LVL_W, 5, width of level and endpoint values.
- LED_W, 16, LED bar width; maximum legal level equals LED_W.
- REP_W, 4, width of the pass-count configuration and status.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: launch from IDLE, resume from PAUSE.
- stop  in  1  single-cycle pulse: pause from RUN, abort from PAUSE.
- start_num  in  LVL_W  sweep origin level.
- end_num  in  LVL_W  sweep target level.
- up_down  in  1  1 = up (origin <= target), 0 = down (origin >= target).
- bounce  in  1  1 = reverse at each endpoint; 0 = reload origin after each pass.
- repeat_cnt  in  REP_W  passes to run; 0 = run indefinitely.
- level  out  LVL_W  current level register.
- led_out  out  LED_W  thermometer code of level: the low `level` bits are set.
- busy  out  1  high in RUN and PAUSE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse when a start is rejected.
- pass_cnt  out  REP_W  passes completed in the current run.

Behaviour:
- Reset (async) values:
  - State IDLE.
  - level=0, led_out=0, busy=0, done=0, err=0, pass_cnt=0.
  - Prescaler count=0.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE + start, with valid config:
  - Latch start_num, end_num, up_down, bounce, repeat_cnt.
  - Next cycle: level=start_num, pass_cnt=0, prescaler=0, state RUN.
- IDLE + start, with invalid config:
  - Invalid means an endpoint > LED_W, or up_down=1 with start_num>end_num, or up_down=0 with start_num<end_num.
  - Response: err pulse in the next cycle; state stays IDLE; level unchanged.
- Tick generation:
  - Prescaler counts only in RUN.
  - Tick fires in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - In PAUSE the count is frozen, not cleared.
- RUN, on each tick:
  - If level != current target: level moves one step toward the target.
  - Else the pass completes: pass_cnt increments (wraps modulo 2^REP_W when repeat_cnt=0). Then:
    - repeat_cnt!=0 and the new pass_cnt == repeat_cnt: go to DONE; level holds.
    - Else if bounce=1: swap target and origin (direction reverses).
    - Else: level reloads to the origin.
  - Each endpoint is therefore displayed for one full tick period.
- start_num == end_num: each pass completes on the first tick.
- RUN + stop: PAUSE; level frozen.
- PAUSE + start: back to RUN.
- PAUSE + stop: abort. Next cycle: IDLE, level=0, pass_cnt=0, no done pulse.
- DONE: done=1 for exactly one cycle, then IDLE. level and pass_cnt hold until the next accepted start.
- start and stop in the same cycle: stop wins (in IDLE, no effect).
- start in RUN: ignored. Input changes outside an accepted start: ignored.
- led_out: combinational decode of the level register. Same-cycle with level; no added latency.
- busy: registered from the state.
- rst mid-operation: all outputs return to their reset values immediately, with no clock edge.

Decomposition:
- Shared package led_pkg:
  - State enum {IDLE, RUN, PAUSE, DONE}.
  - Constants LED_W=16, MAX_LEVEL=16.
  - Thermometer-decode function, reused by the existing display logic.
- Sub-module tick_prescaler:
  - Parameter TICK_DIV.
  - Ports: clk, rst, en, clr, tick.
  - Replaces the free-running divider.
- Controller FSM, level datapath and config checks stay in led_sweep_controller.

Test Plan:
- All scenarios use TICK_DIV=4.
- Up sweep: start_num=3, end_num=6, up_down=1, bounce=0, repeat_cnt=1, start pulse at cycle 0 -> level=3 at cycle 1; 4/5/6 after ticks at cycles 4/8/12; pass completes at cycle 16; done pulse at cycle 17; led_out=0x003F held; pass_cnt=1; busy falls with done.
- Bounce: start_num=0, end_num=2, up_down=1, bounce=1, repeat_cnt=2 -> level sequence 0,1,2,2(pass),1,0,0(pass) -> single done pulse, pass_cnt=2, level=0.
- Rejects: start_num=17 -> one err pulse, busy=0. up_down=1, start_num=9, end_num=4 -> err. up_down=0, start_num=4, end_num=9 -> err. level unchanged in every case.
- Pause/resume/abort: stop at level 5 -> level and prescaler frozen for 20 cycles; start -> next step arrives after the remaining prescaler cycles only. Then stop, stop -> IDLE, level=0, led_out=0, no done.
- Async reset: assert rst mid-RUN between clock edges -> level=0, led_out=0, busy=0 immediately. After release, start in the same cycle as stop -> no launch.
- Infinite run: start_num=15, end_num=16, up_down=1, bounce=0, repeat_cnt=0 -> pass_cnt wraps 15->0 after 16 passes, done never pulses, led_out alternates 0x7FFF/0xFFFF.
